// File: rtl/conv_window_sequencer_if.sv
// Result stream between the convolution window sequencer and its consumer.
// The master drives one result per handshake together with its output coordinate.
interface conv_window_sequencer_if #(
    parameter int RW = 4,
    parameter int CW = 2
);
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic [CW-1:0] res_row;
    logic [CW-1:0] res_col;

    modport master (
        output res_valid,
        output res_data,
        output res_row,
        output res_col,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_row,
        input  res_col,
        output res_ready
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Binary convolution window sequencer: loads an IMG_N x IMG_N image row by row,
// latches a K_N x K_N kernel on start, then walks every valid window position in
// raster order (one tap per cycle) and streams popcount(window & kernel) results.
//
// Build option: define CONV_SEQ_EDGE_DET_EN to edge-detect row_wr/start (direct
// switch inputs). Left undefined, every cycle either strobe is high is an event.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no rows captured
// S_LOAD  | some rows captured, waiting for the rest
// S_READY | image complete, waiting for start
// S_RUN   | accumulating the K_N*K_N taps of the current position
// S_OUT   | result presented, waiting for the consumer handshake
// S_DONE  | one-cycle end-of-frame pulse, then back to S_READY
module conv_window_sequencer #(
    parameter int IMG_N = 6,
    parameter int K_N   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IMG_N-1:0]                 i_row_in,
    input  logic                             i_row_wr,
    input  logic [K_N*K_N-1:0]               i_kernel_in,
    input  logic                             i_start,
    input  logic                             i_clear,
    conv_window_sequencer_if.master          res_if,
    output logic [$clog2(IMG_N+1)-1:0]       o_rows_loaded,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);
    localparam int OUT_N = IMG_N - K_N + 1;
    localparam int RW    = $clog2(K_N*K_N + 1);
    localparam int CW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int LW    = $clog2(IMG_N + 1);
    localparam int PW    = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int KW    = (K_N > 1) ? $clog2(K_N) : 1;
    localparam int TW    = (K_N*K_N > 1) ? $clog2(K_N*K_N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_OUT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IMG_N-1:0]   r_img [IMG_N];
    logic [K_N*K_N-1:0] r_kernel;
    logic [LW-1:0]      r_rows;
    logic               r_err;
    logic [RW-1:0]      r_acc;
    logic [CW-1:0]      r_row;
    logic [CW-1:0]      r_col;
    logic [KW-1:0]      r_kr;
    logic [KW-1:0]      r_kc;

    logic               w_row_ev;
    logic               w_start_ev;
    logic               w_loading;
    logic [LW-1:0]      w_rows_inc;
    logic               w_last_tap;
    logic               w_last_pos;
    logic               w_hs;
    logic [PW-1:0]      w_prow;
    logic [PW-1:0]      w_pcol;
    logic [TW-1:0]      w_kidx;
    logic               w_tap;
    logic [PW-1:0]      w_wr_idx;

`ifdef CONV_SEQ_EDGE_DET_EN
    logic r_row_wr_q;
    logic r_start_q;

    // Previous-cycle samples of the switch strobes for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_wr_q <= 1'b0;
            r_start_q  <= 1'b0;
        end else begin
            r_row_wr_q <= i_row_wr;
            r_start_q  <= i_start;
        end
    end

    assign w_row_ev   = i_row_wr & ~r_row_wr_q;
    assign w_start_ev = i_start & ~r_start_q;
`else
    assign w_row_ev   = i_row_wr;
    assign w_start_ev = i_start;
`endif

    assign w_loading  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_rows_inc = r_rows + LW'(1);
    assign w_last_tap = (r_kr == KW'(K_N-1)) && (r_kc == KW'(K_N-1));
    assign w_last_pos = (r_row == CW'(OUT_N-1)) && (r_col == CW'(OUT_N-1));
    assign w_hs       = (r_state == S_OUT) && res_if.res_ready;
    assign w_prow     = PW'(r_row) + PW'(r_kr);
    assign w_pcol     = PW'(r_col) + PW'(r_kc);
    assign w_kidx     = TW'(r_kr) * TW'(K_N) + TW'(r_kc);
    assign w_tap      = r_img[w_prow][w_pcol] & r_kernel[w_kidx];
    assign w_wr_idx   = PW'(r_rows);

    // State register; reset aborts any operation asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; clear overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_row_ev)
                             w_state_nxt = (w_rows_inc == LW'(IMG_N)) ? S_READY : S_LOAD;
                S_LOAD:  if (w_row_ev && (w_rows_inc == LW'(IMG_N)))
                             w_state_nxt = S_READY;
                S_READY: if (w_start_ev) w_state_nxt = S_RUN;
                S_RUN:   if (w_last_tap) w_state_nxt = S_OUT;
                S_OUT:   if (w_hs) w_state_nxt = w_last_pos ? S_DONE : S_RUN;
                S_DONE:  w_state_nxt = S_READY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Image and kernel storage; deliberately not reset, only written while idle/loading or on start.
    always_ff @(posedge clk) begin
        if (!i_clear && w_row_ev && w_loading)
            r_img[w_wr_idx] <= i_row_in;
        if (!i_clear && w_start_ev && (r_state == S_READY))
            r_kernel <= i_kernel_in;
    end

    // Row counter, sticky error, window position, tap counters and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows <= '0;
            r_err  <= 1'b0;
            r_acc  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_kr   <= '0;
            r_kc   <= '0;
        end else if (i_clear) begin
            r_rows <= '0;
            r_err  <= 1'b0;
            r_acc  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_kr   <= '0;
            r_kc   <= '0;
        end else begin
            if (w_row_ev) begin
                if (w_loading) r_rows <= w_rows_inc;
                else           r_err  <= 1'b1;
            end
            if (w_start_ev && w_loading)
                r_err <= 1'b1;
            case (r_state)
                S_READY: begin
                    if (w_start_ev) begin
                        r_acc <= '0;
                        r_row <= '0;
                        r_col <= '0;
                        r_kr  <= '0;
                        r_kc  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + RW'(w_tap);
                    if (r_kc == KW'(K_N-1)) begin
                        r_kc <= '0;
                        r_kr <= (r_kr == KW'(K_N-1)) ? '0 : r_kr + KW'(1);
                    end else begin
                        r_kc <= r_kc + KW'(1);
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_acc <= '0;
                        if (r_col == CW'(OUT_N-1)) begin
                            r_col <= '0;
                            r_row <= w_last_pos ? '0 : r_row + CW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_if.res_valid = (r_state == S_OUT);
    assign res_if.res_data  = r_acc;
    assign res_if.res_row   = r_row;
    assign res_if.res_col   = r_col;
    assign o_rows_loaded    = r_rows;
    assign o_busy           = (r_state == S_RUN) || (r_state == S_OUT);
    assign o_done           = (r_state == S_DONE);
    assign o_err            = r_err;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: full frames on several images and
// kernels, backpressure hold, protocol errors, clear and async reset.
module tb_conv_window_sequencer;
    localparam int IMG_N = 6;
    localparam int K_N   = 3;
    localparam int OUT_N = 4;
    localparam int RW    = 4;
    localparam int CW    = 2;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IMG_N-1:0] i_row_in = '0;
    logic             i_row_wr = 1'b0;
    logic [8:0]       i_kernel_in = '0;
    logic             i_start = 1'b0;
    logic             i_clear = 1'b0;
    logic [LW-1:0]    o_rows_loaded;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int checks = 0;
    int errors = 0;
    int exp_res [OUT_N*OUT_N];

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.RW(RW), .CW(CW)) res_if ();

    conv_window_sequencer #(.IMG_N(IMG_N), .K_N(K_N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_row_in      (i_row_in),
        .i_row_wr      (i_row_wr),
        .i_kernel_in   (i_kernel_in),
        .i_start       (i_start),
        .i_clear       (i_clear),
        .res_if        (res_if.master),
        .o_rows_loaded (o_rows_loaded),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_row(input logic [IMG_N-1:0] data);
        i_row_in = data;
        i_row_wr = 1'b1;
        tick();
        i_row_wr = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic [8:0] kern);
        i_kernel_in = kern;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    // Consumes one frame with res_ready high, comparing each result to exp_res.
    task automatic run_frame(input bit chk_first_lat, input string tag);
        int n;
        for (int p = 0; p < OUT_N*OUT_N; p++) begin
            n = 0;
            while (res_if.res_valid !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check({tag, "_valid"}, res_if.res_valid, 1);
            if (chk_first_lat || p > 0) check({tag, "_lat"}, n, 9);
            check({tag, "_data"}, res_if.res_data, exp_res[p]);
            check({tag, "_row"}, res_if.res_row, p / OUT_N);
            check({tag, "_col"}, res_if.res_col, p % OUT_N);
            check({tag, "_busy"}, o_busy, 1);
            tick();
        end
        check({tag, "_done_hi"}, o_done, 1);
        check({tag, "_busy_lo"}, o_busy, 0);
        check({tag, "_valid_lo"}, res_if.res_valid, 0);
        tick();
        check({tag, "_done_lo"}, o_done, 0);
    endtask

    initial begin
        int n;
        res_if.res_ready = 1'b0;
        tick(2);
        check("rst_valid", res_if.res_valid, 0);
        check("rst_data", res_if.res_data, 0);
        check("rst_row", res_if.res_row, 0);
        check("rst_col", res_if.res_col, 0);
        check("rst_rows", o_rows_loaded, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        rst_n = 1'b1;
        tick();

        // All-ones image, full kernel: every window sums to 9
        for (int r = 0; r < IMG_N; r++) write_row(6'h3F);
        check("ones_rows", o_rows_loaded, 6);
        check("ones_err", o_err, 0);
        for (int p = 0; p < 16; p++) exp_res[p] = 9;
        res_if.res_ready = 1'b1;
        pulse_start(9'h1FF);
        check("ones_busy_run", o_busy, 1);
        run_frame(1'b1, "ones");

        // Centre tap only on retained image, with backpressure at the first result
        res_if.res_ready = 1'b0;
        pulse_start(9'h010);
        n = 0;
        while (res_if.res_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("bp_lat", n, 9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", res_if.res_valid, 1);
            check("bp_data", res_if.res_data, 1);
            check("bp_row", res_if.res_row, 0);
            check("bp_col", res_if.res_col, 0);
        end
        for (int p = 0; p < 16; p++) exp_res[p] = 1;
        res_if.res_ready = 1'b1;
        run_frame(1'b0, "ctr");

        // Checkerboard: pixel(r,c)=1 when r+c odd, windows give 4 or 5
        pulse_clear();
        check("clr_rows", o_rows_loaded, 0);
        check("clr_valid", res_if.res_valid, 0);
        for (int r = 0; r < IMG_N; r++) write_row((r % 2 == 0) ? 6'b101010 : 6'b010101);
        exp_res = '{4, 5, 4, 5, 5, 4, 5, 4, 4, 5, 4, 5, 5, 4, 5, 4};
        pulse_start(9'h1FF);
        run_frame(1'b1, "chk");
        check("chk_err", o_err, 0);

        // Start during LOAD is an error and is ignored
        pulse_clear();
        for (int r = 0; r < 3; r++) write_row(6'h3F);
        pulse_start(9'h1FF);
        check("early_err", o_err, 1);
        check("early_rows", o_rows_loaded, 3);
        check("early_busy", o_busy, 0);
        tick(12);
        check("early_valid", res_if.res_valid, 0);
        for (int r = 0; r < 3; r++) write_row(6'h3F);
        check("early_rows6", o_rows_loaded, 6);
        for (int p = 0; p < 16; p++) exp_res[p] = 9;
        pulse_start(9'h1FF);
        run_frame(1'b1, "late");
        check("late_err_sticky", o_err, 1);
        write_row(6'h00);
        check("ready_row_rows", o_rows_loaded, 6);
        pulse_clear();
        check("clr_err", o_err, 0);

        // row_wr held high for 20 cycles
        i_row_in = 6'h3F;
        i_row_wr = 1'b1;
        tick(20);
        i_row_wr = 1'b0;
        tick();
`ifdef CONV_SEQ_EDGE_DET_EN
        check("held_rows", o_rows_loaded, 1);
        check("held_err", o_err, 0);
`else
        check("held_rows", o_rows_loaded, 6);
        check("held_err", o_err, 1);
`endif
        pulse_clear();

        // Asynchronous reset in the middle of RUN
        for (int r = 0; r < IMG_N; r++) write_row(6'h3F);
        pulse_start(9'h1FF);
        tick(4);
        check("mid_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_valid", res_if.res_valid, 0);
        check("arst_data", res_if.res_data, 0);
        check("arst_rows", o_rows_loaded, 0);
        check("arst_done", o_done, 0);
        check("arst_err", o_err, 0);
        #3;
        rst_n = 1'b1;
        tick();

        // clear while holding a result in OUT
        for (int r = 0; r < IMG_N; r++) write_row(6'h3F);
        res_if.res_ready = 1'b0;
        pulse_start(9'h1FF);
        n = 0;
        while (res_if.res_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("out_valid", res_if.res_valid, 1);
        check("out_data", res_if.res_data, 9);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("oclr_valid", res_if.res_valid, 0);
        check("oclr_rows", o_rows_loaded, 0);
        check("oclr_busy", o_busy, 0);
        tick(3);
        check("oclr_stay", res_if.res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Controller for the binary convolution layer. It collects a square input image one row at a time from switch-style strobes and latches a binary kernel. It then walks the kernel window over every valid position in raster order, accumulating one tap per cycle. Each result is streamed out over a valid/ready handshake together with its output coordinate. It sits between the top-level switch/IO logic and the downstream result consumer, and owns all load, start, abort and backpressure sequencing for the layer.

## Interface
- IMG_N, 6, image side length in pixels (rows and columns).
- K_N, 3, kernel side length; OUT_N = IMG_N-K_N+1 output positions per axis.
- RW, derived, clog2(K_N*K_N+1), result width (4 at defaults).
- CW, derived, clog2(OUT_N), coordinate width (2 at defaults).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- row_in  in  IMG_N  pixel row; bit c is column c.
- row_wr  in  1  row write strobe, level from switch.
- kernel_in  in  K_N*K_N  kernel taps; bit kr*K_N+kc.
- start  in  1  start strobe, level from switch.
- clear  in  1  synchronous abort: go to IDLE, rows_loaded=0.
- res_ready  in  1  consumer ready.
- res_valid  out  1  result valid.
- res_data  out  RW  popcount(window AND kernel).
- res_row, res_col  out  CW  output coordinate of res_data.
- rows_loaded  out  clog2(IMG_N+1)  rows captured so far.
- busy  out  1  high in RUN and OUT.
- done  out  1  one-cycle pulse after the last handshake.
- err  out  1  sticky protocol error; cleared only by clear or reset.

## Operation
- States: IDLE, LOAD, READY, RUN, OUT, DONE.
- A row event is a rising edge of row_wr: the previous-cycle sample was 0 and the current sample is 1.
- In IDLE or LOAD, a row event writes row_in to row[rows_loaded] and increments rows_loaded.
  - IDLE moves to LOAD on the first row.
  - LOAD moves to READY when rows_loaded reaches IMG_N.
- A start event is a rising edge of start.
  - In READY it latches kernel_in, resets the position to (0,0), clears the accumulator and enters RUN.
  - In IDLE or LOAD it sets err and is otherwise ignored.
- A row event in READY, RUN, OUT or DONE sets err and is ignored. The image is never overwritten.
- RUN takes K_N*K_N cycles per position. Tap order is kr-major, then kc.
  - Each cycle: acc += row[r+kr][c+kc] & kernel[kr*K_N+kc].
  - After the last tap, go to OUT.
- OUT drives res_valid=1, res_data=acc, res_row=r, res_col=c.
  - These outputs hold stable until res_valid && res_ready.
  - On the handshake, c increments. When c wraps past OUT_N-1 it returns to 0 and r increments.
  - The accumulator clears and the block returns to RUN.
  - After the handshake for (OUT_N-1, OUT_N-1), go to DONE.
- DONE asserts done for one cycle, then returns to READY. The image is retained, so a new start recomputes it.
- clear has priority over every other event. It takes effect next cycle from any state: IDLE, rows_loaded=0, err=0, res_valid=0.
- A row event and a start event in the same cycle are handled per the current state's rules. In LOAD, a start arriving with the final row sets err.

## Timing
- Reset values: res_valid=0, res_data=0, res_row=0, res_col=0, rows_loaded=0, busy=0, done=0, err=0, state=IDLE. Row storage is not reset.
- rst_n low aborts any operation immediately and asynchronously.
- A start event sampled at edge t puts RUN active in cycles t+1..t+K_N*K_N. res_valid first rises at t+K_N*K_N+1 (t+10 at defaults).
- With res_ready held high, results are spaced K_N*K_N+1 cycles apart (10 cycles). One full frame takes OUT_N²·10 = 160 cycles.
- done is high in the cycle after the final handshake. busy drops in that same cycle.
- res_valid never deasserts without a handshake, except on clear or reset.

## Configuration
- CONV_SEQ_EDGE_DET_EN defined:
  - row_wr and start are edge-detected as described above.
  - This is the default for direct switch inputs.
- CONV_SEQ_EDGE_DET_EN undefined:
  - row_wr and start are treated as single-cycle pulses. Every cycle they are high counts as an event.
  - The edge-detect flops are removed.
  - Upstream logic must supply clean pulses.

## Test plan
- All-ones image, kernel 9'h1FF, start, res_ready=1 -> 16 results of value 9 in raster order (0,0),(0,1)…(3,3). First result at start+10 cycles, spacing 10 cycles. done pulses once after (3,3).
- Checkerboard image with rows alternating 6'b101010/6'b010101, kernel 9'h1FF -> results alternate 5 and 4 along each row and down each column.
- Kernel 9'h010 (center tap only) on an all-ones image -> all results 1. Then hold res_ready=0 for 5 cycles at the first result -> res_valid, res_data, res_row and res_col stay stable, with no advance.
- start after 3 rows -> err=1, state stays LOAD, res_valid stays 0. Three more rows then start -> normal frame; err remains 1 until clear.
- row_wr held high for 20 cycles -> rows_loaded increments by exactly 1 with the macro defined, and by 6 (saturating into READY) without it.
- rst_n low mid-RUN -> all outputs at reset values immediately. clear mid-OUT -> IDLE next cycle with res_valid=0 and rows_loaded=0.
